// File: rtl/fpu_pkg.sv
// Shared opcodes, constants and types for the FPU job issuer.
package fpu_pkg;

  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_MUL = 2'b01;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } fpu_job_t;

endpackage

// File: rtl/fpu_job_fifo.sv
// Job buffer between the request port and the issuer FSM; full/empty come
// straight from the occupancy register so job_ready never depends on the pop side.
module fpu_job_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fpu_job_t                   wdata_i,
  input  logic                       pop_i,
  output fpu_job_t                   rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fpu_job_t        mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + PW'(1);
      if (doPop)  rptr_q <= rptr_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issuer.sv
// Requester side of the FPU start/done handshake: queues jobs, issues them one
// at a time, and returns results (or a timeout NaN) in order.
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_op,
  input  logic [31:0]                job_a,
  input  logic [31:0]                job_b,
  output logic                       fpu_start,
  output logic [1:0]                 fpu_op,
  output logic [31:0]                fpu_in_a,
  output logic [31:0]                fpu_in_b,
  input  logic [31:0]                fpu_out,
  input  logic                       fpu_done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic                       res_timeout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  issuer_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          resValid_q, resValid_d;
  logic [31:0]   resData_q, resData_d;
  logic          resTimeout_q, resTimeout_d;

  logic          fifoFull, fifoEmpty, fifoPop;
  fpu_job_t      fifoHead, fifoWdata;

  assign fifoWdata = '{op: job_op, a: job_a, b: job_b};
  assign job_ready = !fifoFull;

  fpu_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (job_valid && job_ready),
    .wdata_i (fifoWdata),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      start_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resValid_q   <= 1'b0;
      resData_q    <= '0;
      resTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resValid_q   <= resValid_d;
      resData_q    <= resData_d;
      resTimeout_q <= resTimeout_d;
    end
  end

  // Operand registers only load in IDLE, so they stay frozen throughout ISSUE.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    start_d      = start_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    resValid_d   = resValid_q && !res_ready;
    resData_d    = resData_q;
    resTimeout_d = resTimeout_q;
    fifoPop      = 1'b0;

    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (!fifoEmpty && !fpu_done) begin
          fifoPop = 1'b1;
          op_d    = fifoHead.op;
          a_d     = fifoHead.a;
          b_d     = fifoHead.b;
          start_d = 1'b1;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (fpu_done) begin
          resData_d    = fpu_out;
          resTimeout_d = 1'b0;
          resValid_d   = 1'b1;
          start_d      = 1'b0;
          state_d      = RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resData_d    = QNAN;
          resTimeout_d = 1'b1;
          resValid_d   = 1'b1;
          start_d      = 1'b0;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        start_d = 1'b0;
        // Wait for done to drop and the result to be taken before re-arming.
        if (!fpu_done && (!resValid_q || res_ready)) begin
          state_d = IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign fpu_start   = start_q;
  assign fpu_op      = op_q;
  assign fpu_in_a    = a_q;
  assign fpu_in_b    = b_q;
  assign res_valid   = resValid_q;
  assign res_data    = resData_q;
  assign res_timeout = resTimeout_q;
  assign busy        = (state_q != IDLE) || !fifoEmpty;

endmodule
